// File: rtl/font_bram_pkg.sv
// Shared types and constants for the font BRAM controller: fill FSM states
// and the two supported read latencies.
package font_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int unsigned LAT_DIRECT = 1;
  localparam int unsigned LAT_OUTREG = 2;

endpackage

// File: rtl/font_bram_core.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on
// the array so synthesis maps it onto block RAM.
module font_bram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Sharing one block with non-blocking writes gives read-before-write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/font_bram_ctrl.sv
// Font memory controller: never-stalling video read port, host write port and
// a fill engine that owns the write port while a fill is running.
module font_bram_ctrl
  import font_bram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 13,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_count,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(1);
  localparam int unsigned     READ_LAT = (OUT_REG != 0) ? LAT_OUTREG : LAT_DIRECT;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] fillAddr_q, fillAddr_d;
  logic [ADDR_W:0]   fillCnt_q, fillCnt_d;
  logic [DATA_W-1:0] fillVal_q, fillVal_d;
  logic              clrPend_q;
  logic              memWe;
  logic [ADDR_W-1:0] memWaddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] coreRdata;
  logic              rdValid1_q;

  // clrPend_q requests one full-memory zero fill on the first edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      fillAddr_q <= '0;
      fillCnt_q  <= '0;
      fillVal_q  <= '0;
      clrPend_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q    <= state_d;
      fillAddr_q <= fillAddr_d;
      fillCnt_q  <= fillCnt_d;
      fillVal_q  <= fillVal_d;
      clrPend_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    fillAddr_d = fillAddr_q;
    fillCnt_d  = fillCnt_q;
    fillVal_d  = fillVal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clrPend_q) begin
          state_d    = ST_FILL;
          fillAddr_d = '0;
          fillCnt_d  = FULL_CNT;
          fillVal_d  = '0;
        end else if (fill_start) begin
          state_d    = ST_FILL;
          fillAddr_d = fill_base;
          fillCnt_d  = (fill_count == '0) ? FULL_CNT : {1'b0, fill_count};
          fillVal_d  = fill_value;
        end
      end
      ST_FILL: begin
        fillAddr_d = fillAddr_q + ADDR_W'(1);
        fillCnt_d  = fillCnt_q - (ADDR_W+1)'(1);
        if (fillCnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The fill engine has priority on the single write port; the host is held off.
  always_comb begin
    fill_busy = (state_q == ST_FILL);
    fill_done = (state_q == ST_DONE);
    wr_ready  = (state_q != ST_FILL);
    memWe     = wr_en;
    memWaddr  = wr_addr;
    memWdata  = wr_data;
    if (state_q == ST_FILL) begin
      memWe    = 1'b1;
      memWaddr = fillAddr_q;
      memWdata = fillVal_q;
    end
  end

  font_bram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uCore (
    .clk_i  (clk),
    .we_i   (memWe),
    .waddr_i(memWaddr),
    .wdata_i(memWdata),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(coreRdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdValid1_q <= 1'b0;
    else          rdValid1_q <= rd_en;
  end

  generate
    if (READ_LAT == LAT_OUTREG) begin : gOutReg
      logic              rdValid2_q;
      logic [DATA_W-1:0] rdData_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rdValid2_q <= 1'b0;
          rdData_q   <= '0;
        end else begin
          rdValid2_q <= rdValid1_q;
          if (rdValid1_q) rdData_q <= coreRdata;
        end
      end

      assign rd_valid = rdValid2_q;
      assign rd_data  = rdData_q;
    end else begin : gDirect
      // The RAM output register has no reset, so mask it until the first read.
      logic seen_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) seen_q <= 1'b0;
        else          seen_q <= seen_q | rd_en;
      end

      assign rd_valid = rdValid1_q;
      assign rd_data  = seen_q ? coreRdata : '0;
    end
  endgenerate

endmodule

// File: tb/tb_font_bram_ctrl.sv
// Directed bench for font_bram_ctrl: a reference memory model feeds a read
// scoreboard, plus a second instance exercising clear-on-reset with OUT_REG=1.
module tb_font_bram_ctrl;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rd_en;
  logic [12:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        fill_start;
  logic [12:0] fill_base;
  logic [12:0] fill_count;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;

  logic        resetClr_n;
  logic        rdEnC;
  logic [3:0]  rdAddrC;
  logic [7:0]  rdDataC;
  logic        rdValidC;
  logic        wrEnC;
  logic [3:0]  wrAddrC;
  logic [7:0]  wrDataC;
  logic        wrReadyC;
  logic        fillStartC;
  logic [3:0]  fillBaseC;
  logic [3:0]  fillCountC;
  logic [7:0]  fillValueC;
  logic        fillBusyC;
  logic        fillDoneC;

  logic [7:0]  model [8192];
  exp_t        expQ[$];
  int          cyc = 0;
  int          nAsserts = 0;
  int          nFails = 0;
  logic [7:0]  lastData = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  font_bram_ctrl #(
    .DATA_W(8), .ADDR_W(13), .OUT_REG(0), .CLEAR_ON_RESET(0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done)
  );

  font_bram_ctrl #(
    .DATA_W(8), .ADDR_W(4), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) dutClr (
    .clk(clk), .reset_n(resetClr_n),
    .rd_en(rdEnC), .rd_addr(rdAddrC), .rd_data(rdDataC), .rd_valid(rdValidC),
    .wr_en(wrEnC), .wr_addr(wrAddrC), .wr_data(wrDataC), .wr_ready(wrReadyC),
    .fill_start(fillStartC), .fill_base(fillBaseC), .fill_count(fillCountC),
    .fill_value(fillValueC), .fill_busy(fillBusyC), .fill_done(fillDoneC)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [12:0] wa, input logic [7:0] wd,
                               input logic re, input logic [12:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    if (re) expQ.push_back(exp_t'{data: model[ra], due: cyc + 1});
  endtask

  task automatic readWord(input logic [12:0] a);
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b1, a);
    @(negedge clk);
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
  endtask

  task automatic hostWrite(input logic [12:0] a, input logic [7:0] d);
    int g;
    g = 0;
    applyStimulus(1'b1, a, d, 1'b0, 13'h0);
    while (wr_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    checkOutput("wr_ready_wait", wr_ready, 1);
    @(negedge clk);
    model[a] = d;
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
  endtask

  task automatic runFill(input logic [12:0] base, input logic [12:0] cnt, input logic [7:0] val,
                         input int expBusy);
    int busy;
    logic [12:0] a;
    busy = 0;
    fill_start = 1'b1;
    fill_base  = base;
    fill_count = cnt;
    fill_value = val;
    @(negedge clk);
    fill_start = 1'b0;
    while (fill_busy === 1'b1 && busy < 10000) begin
      busy++;
      @(negedge clk);
    end
    checkOutput("fill_busy_cycles", busy, expBusy);
    checkOutput("fill_done_pulse", fill_done, 1);
    @(negedge clk);
    checkOutput("fill_done_clear", fill_done, 0);
    for (int i = 0; i < expBusy; i++) begin
      a = base + 13'(i);
      model[a] = val;
    end
  endtask

  task automatic clrCheckFill();
    int busy, dones, notReady;
    busy = 0; dones = 0; notReady = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      busy     += int'(fillBusyC);
      dones    += int'(fillDoneC);
      notReady += int'(!wrReadyC);
    end
    checkOutput("clr_busy_cycles", busy, 16);
    checkOutput("clr_done_pulses", dones, 1);
    checkOutput("clr_wr_ready_low", notReady, 16);
  endtask

  task automatic clrSweep();
    for (int i = 0; i < 18; i++) begin
      rdEnC   = (i < 16);
      rdAddrC = 4'(i);
      @(negedge clk);
      if (i == 0 || i == 17) begin
        checkOutput("clr_sweep_idle_valid", rdValidC, 0);
      end else begin
        checkOutput("clr_sweep_valid", rdValidC, 1);
        checkOutput("clr_sweep_data", rdDataC, 0);
      end
    end
    rdEnC = 1'b0;
  endtask

  // Read scoreboard: data and latency on valid, hold value otherwise.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      lastData = 8'h00;
    end else if (rd_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rd_spurious_valid", rd_valid, 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rd_data", rd_data, e.data);
        checkOutput("rd_latency", cyc, e.due);
      end
      lastData = rd_data;
    end else begin
      checkOutput("rd_hold", rd_data, lastData);
      if (expQ.size() != 0 && expQ[0].due <= cyc) begin
        checkOutput("rd_missing_valid", rd_valid, 1);
        expQ.delete(0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [12:0] a;
    int nr, b, d;

    reset_n = 1'b0; resetClr_n = 1'b0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    rdEnC = 1'b0; rdAddrC = '0; wrEnC = 1'b0; wrAddrC = '0; wrDataC = '0;
    fillStartC = 1'b0; fillBaseC = '0; fillCountC = '0; fillValueC = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_fill_busy", fill_busy, 0);
    checkOutput("rst_fill_done", fill_done, 0);
    checkOutput("rst_wr_ready", wr_ready, 1);
    checkOutput("rstC_rd_data", rdDataC, 0);
    checkOutput("rstC_rd_valid", rdValidC, 0);
    checkOutput("rstC_fill_busy", fillBusyC, 0);
    checkOutput("rstC_wr_ready", wrReadyC, 1);

    // Clear-on-reset instance: zero fill, dirty a word, reset again, re-verify.
    resetClr_n = 1'b1;
    clrCheckFill();
    clrSweep();
    wrEnC = 1'b1; wrAddrC = 4'h5; wrDataC = 8'hEE;
    @(negedge clk);
    wrEnC = 1'b0;
    rdEnC = 1'b1; rdAddrC = 4'h5;
    @(negedge clk);
    rdEnC = 1'b0;
    checkOutput("clr_lat2_not_yet", rdValidC, 0);
    @(negedge clk);
    checkOutput("clr_lat2_valid", rdValidC, 1);
    checkOutput("clr_lat2_data", rdDataC, 8'hEE);
    @(negedge clk);
    checkOutput("clr_lat2_drop", rdValidC, 0);
    checkOutput("clr_lat2_hold", rdDataC, 8'hEE);
    resetClr_n = 1'b0;
    #1;
    checkOutput("clr_rst_data", rdDataC, 0);
    checkOutput("clr_rst_busy", fillBusyC, 0);
    @(negedge clk);
    resetClr_n = 1'b1;
    clrCheckFill();
    clrSweep();

    // Main instance.
    reset_n = 1'b1;
    @(negedge clk);
    hostWrite(13'h0010, 8'h5A);
    readWord(13'h0010);

    hostWrite(13'h0100, 8'h11);
    applyStimulus(1'b1, 13'h0100, 8'h22, 1'b1, 13'h0100);
    @(negedge clk);
    model[13'h0100] = 8'h22;
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    readWord(13'h0100);

    hostWrite(13'h0000, 8'h01);
    hostWrite(13'h1FFF, 8'h80);
    hostWrite(13'h0AAA, 8'hC3);
    readWord(13'h0000);
    readWord(13'h1FFF);
    readWord(13'h0AAA);
    readWord(13'h0010);

    // Wrapping fill across the top of memory.
    hostWrite(13'h0002, 8'h3C);
    hostWrite(13'h1FFD, 8'h44);
    runFill(13'h1FFE, 13'd4, 8'hFF, 4);
    for (int i = 0; i < 6; i++) begin
      a = 13'h1FFD + 13'(i);
      readWord(a);
    end

    // Host write held through a fill; a second fill_start mid-fill is ignored.
    hostWrite(13'h0203, 8'h33);
    hostWrite(13'h0600, 8'h5E);
    hostWrite(13'h0300, 8'h10);
    fill_start = 1'b1; fill_base = 13'h0200; fill_count = 13'd3; fill_value = 8'h77;
    @(negedge clk);
    fill_base = 13'h0600; fill_count = 13'd5; fill_value = 8'h01;
    applyStimulus(1'b1, 13'h0300, 8'hC3, 1'b0, 13'h0);
    nr = 0;
    while (wr_ready !== 1'b1 && nr < 20) begin
      nr++;
      @(negedge clk);
      fill_start = 1'b0;
    end
    checkOutput("held_wr_not_ready_cycles", nr, 3);
    checkOutput("held_wr_in_done", fill_done, 1);
    @(negedge clk);
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    model[13'h0300] = 8'hC3;
    for (int i = 0; i < 3; i++) model[13'h0200 + 13'(i)] = 8'h77;
    checkOutput("ignored_start_busy", fill_busy, 0);
    checkOutput("ignored_start_done", fill_done, 0);
    readWord(13'h0200);
    readWord(13'h0202);
    readWord(13'h0203);
    readWord(13'h0300);
    readWord(13'h0600);

    // fill_start and wr_en together in IDLE.
    fill_start = 1'b1; fill_base = 13'h0500; fill_count = 13'd2; fill_value = 8'h12;
    applyStimulus(1'b1, 13'h0400, 8'h99, 1'b0, 13'h0);
    checkOutput("same_cycle_wr_ready", wr_ready, 1);
    @(negedge clk);
    fill_start = 1'b0;
    applyStimulus(1'b0, 13'h0, 8'h0, 1'b0, 13'h0);
    model[13'h0400] = 8'h99;
    b = 0;
    while (fill_busy === 1'b1 && b < 20) begin
      b++;
      @(negedge clk);
    end
    checkOutput("same_cycle_fill_busy", b, 2);
    checkOutput("same_cycle_fill_done", fill_done, 1);
    model[13'h0500] = 8'h12;
    model[13'h0501] = 8'h12;
    @(negedge clk);
    readWord(13'h0400);
    readWord(13'h0500);
    readWord(13'h0501);

    // Reset in the middle of a 100-word fill, after 50 words are written.
    runFill(13'h0000, 13'd100, 8'hA5, 100);
    fill_start = 1'b1; fill_base = 13'h0000; fill_count = 13'd100; fill_value = 8'h5C;
    @(negedge clk);
    fill_start = 1'b0;
    repeat (50) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_fill_busy", fill_busy, 0);
    checkOutput("abort_rd_valid", rd_valid, 0);
    checkOutput("abort_fill_done", fill_done, 0);
    checkOutput("abort_wr_ready", wr_ready, 1);
    checkOutput("abort_rd_data", rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    d = 0;
    repeat (5) begin
      @(negedge clk);
      d += int'(fill_done);
    end
    checkOutput("abort_no_done", d, 0);
    for (int i = 0; i < 50; i++) model[13'(i)] = 8'h5C;
    readWord(13'd0);
    readWord(13'd25);
    readWord(13'd49);
    readWord(13'd50);
    readWord(13'd75);
    readWord(13'd99);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
